// File: rtl/jtag_axi_master_pkg.sv
// Shared types for the JTAG-to-AXI4-Lite master: transaction status codes,
// AXI response encodings and the sequencer state enum.
package jtag_axi_master_pkg;

   typedef enum logic [2:0] {
      STS_IDLE    = 3'd0,
      STS_BUSY    = 3'd1,
      STS_OKAY    = 3'd2,
      STS_SLVERR  = 3'd3,
      STS_DECERR  = 3'd4,
      STS_TIMEOUT = 3'd5
   } axi_txn_status_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StWrResp,
      StRdReq,
      StRdResp
   } jtag_axi_fsm_t;

   // EXOKAY is folded into OKAY: the debugger only cares whether the access landed.
   function automatic axi_txn_status_t map_resp(input logic [1:0] resp);
      axi_txn_status_t sts;
      case (resp)
         AXI_RESP_OKAY, AXI_RESP_EXOKAY: sts = STS_OKAY;
         AXI_RESP_SLVERR:                sts = STS_SLVERR;
         default:                        sts = STS_DECERR;
      endcase
      return sts;
   endfunction

endpackage

// File: rtl/jtag_axi_master_if.sv
// AXI4-Lite bus between the JTAG master and the interconnect.
interface jtag_axi_master_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/jtag_axi_master_timeout.sv
// Saturating outstanding-transaction counter; o_expired flags the limit.
// A limit of 0 disables expiry entirely.
module jtag_axi_master_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 4095
) (
   input  logic i_tck,
   input  logic i_trstn,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

   logic [CntW-1:0] r_cnt;

   always_ff @(posedge i_tck or negedge i_trstn) begin
      if (!i_trstn) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != Limit)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (TIMEOUT_CYCLES != 0) && (r_cnt == Limit);
endmodule

// File: rtl/jtag_axi_master.sv
// Issues one AXI4-Lite read or write per JTAG command and reports the outcome
// as a status word plus captured read data, all in the tck domain.
module jtag_axi_master
   import jtag_axi_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 4095,
   parameter logic [2:0]  AXI_PROT       = 3'b000
) (
   input  logic                     i_tck,
   input  logic                     i_trstn,
   input  logic                     i_cmd_valid,
   input  logic                     i_cmd_write,
   input  logic [31:0]              i_cmd_addr,
   input  logic [31:0]              i_cmd_wdata,
   input  logic [3:0]               i_cmd_wstrb,
   input  logic                     i_status_clr,
   output logic                     o_busy,
   output axi_txn_status_t          o_status,
   output logic [31:0]              o_rdata,
   output logic                     o_overrun,
   jtag_axi_master_if.master        m_axi
);
   jtag_axi_fsm_t   r_state, w_state_d;
   axi_txn_status_t r_status, w_status_d;
   logic            r_busy, w_busy_d;
   logic            r_overrun, w_overrun_d;
   logic [31:0]     r_rdata, w_rdata_d;
   logic [31:0]     r_addr, w_addr_d;
   logic [31:0]     r_wdata, w_wdata_d;
   logic [3:0]      r_wstrb, w_wstrb_d;
   logic            r_awvalid, w_awvalid_d;
   logic            r_wvalid, w_wvalid_d;
   logic            r_bready, w_bready_d;
   logic            r_arvalid, w_arvalid_d;
   logic            r_rready, w_rready_d;
   logic            r_aw_done, w_aw_done_d;
   logic            r_w_done, w_w_done_d;

   logic w_start, w_aw_fire, w_w_fire, w_expired, w_timed_out;

   assign w_start     = (r_state == StIdle) && i_cmd_valid;
   assign w_aw_fire   = r_awvalid && m_axi.awready;
   assign w_w_fire    = r_wvalid && m_axi.wready;
   assign w_timed_out = (r_status == STS_TIMEOUT) || w_expired;

   jtag_axi_master_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_tck     (i_tck),
      .i_trstn   (i_trstn),
      .i_clr     (w_start),
      .i_en      (r_busy),
      .o_expired (w_expired)
   );

   always_ff @(posedge i_tck or negedge i_trstn) begin
      if (!i_trstn) begin
         r_state   <= StIdle;
         r_status  <= STS_IDLE;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
         r_rdata   <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_status  <= w_status_d;
         r_busy    <= w_busy_d;
         r_overrun <= w_overrun_d;
         r_rdata   <= w_rdata_d;
         r_addr    <= w_addr_d;
         r_wdata   <= w_wdata_d;
         r_wstrb   <= w_wstrb_d;
         r_awvalid <= w_awvalid_d;
         r_wvalid  <= w_wvalid_d;
         r_bready  <= w_bready_d;
         r_arvalid <= w_arvalid_d;
         r_rready  <= w_rready_d;
         r_aw_done <= w_aw_done_d;
         r_w_done  <= w_w_done_d;
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_status_d  = r_status;
      w_busy_d    = r_busy;
      w_overrun_d = r_overrun;
      w_rdata_d   = r_rdata;
      w_addr_d    = r_addr;
      w_wdata_d   = r_wdata;
      w_wstrb_d   = r_wstrb;
      w_awvalid_d = r_awvalid;
      w_wvalid_d  = r_wvalid;
      w_bready_d  = r_bready;
      w_arvalid_d = r_arvalid;
      w_rready_d  = r_rready;
      w_aw_done_d = r_aw_done;
      w_w_done_d  = r_w_done;

      if (i_status_clr) begin
         w_overrun_d = 1'b0;
      end else if (i_cmd_valid && r_busy) begin
         w_overrun_d = 1'b1;
      end

      // Valids stay up past expiry; only the reported status changes.
      if (r_busy && w_expired) begin
         w_status_d = STS_TIMEOUT;
      end

      unique case (r_state)
         StIdle: begin
            if (i_cmd_valid) begin
               w_addr_d   = i_cmd_addr;
               w_wdata_d  = i_cmd_wdata;
               w_wstrb_d  = i_cmd_wstrb;
               w_busy_d   = 1'b1;
               w_status_d = STS_BUSY;
               if (i_cmd_write) begin
                  w_state_d   = StWrReq;
                  w_awvalid_d = 1'b1;
                  w_wvalid_d  = 1'b1;
                  w_aw_done_d = 1'b0;
                  w_w_done_d  = 1'b0;
               end else begin
                  w_state_d   = StRdReq;
                  w_arvalid_d = 1'b1;
               end
            end else if (i_status_clr) begin
               w_status_d = STS_IDLE;
            end
         end
         StWrReq: begin
            if (w_aw_fire) begin
               w_awvalid_d = 1'b0;
               w_aw_done_d = 1'b1;
            end
            if (w_w_fire) begin
               w_wvalid_d = 1'b0;
               w_w_done_d = 1'b1;
            end
            if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
               w_state_d  = StWrResp;
               w_bready_d = 1'b1;
            end
         end
         StWrResp: begin
            if (r_bready && m_axi.bvalid) begin
               w_bready_d = 1'b0;
               w_busy_d   = 1'b0;
               w_state_d  = StIdle;
               w_status_d = w_timed_out ? STS_TIMEOUT : map_resp(m_axi.bresp);
            end
         end
         StRdReq: begin
            if (r_arvalid && m_axi.arready) begin
               w_arvalid_d = 1'b0;
               w_rready_d  = 1'b1;
               w_state_d   = StRdResp;
            end
         end
         StRdResp: begin
            if (r_rready && m_axi.rvalid) begin
               w_rready_d = 1'b0;
               w_busy_d   = 1'b0;
               w_state_d  = StIdle;
               // A response arriving after expiry is drained but not reported.
               if (w_timed_out) begin
                  w_status_d = STS_TIMEOUT;
               end else begin
                  w_status_d = map_resp(m_axi.rresp);
                  w_rdata_d  = m_axi.rdata;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign o_busy    = r_busy;
   assign o_status  = r_status;
   assign o_rdata   = r_rdata;
   assign o_overrun = r_overrun;

   assign m_axi.awvalid = r_awvalid;
   assign m_axi.awaddr  = r_addr;
   assign m_axi.awprot  = AXI_PROT;
   assign m_axi.wvalid  = r_wvalid;
   assign m_axi.wdata   = r_wdata;
   assign m_axi.wstrb   = r_wstrb;
   assign m_axi.bready  = r_bready;
   assign m_axi.arvalid = r_arvalid;
   assign m_axi.araddr  = r_addr;
   assign m_axi.arprot  = AXI_PROT;
   assign m_axi.rready  = r_rready;
endmodule

// File: doc/jtag_axi_master.md
Name: jtag_axi_master

Overview:
- Sequences one AXI4-Lite transaction per JTAG command, using the address, write data and strobes latched by the JTAG data registers.
- Sits in the tck domain between the data-register block and the AXI4-Lite interconnect.
- Returns read data and a transaction status word, which the data-register block captures on the next CAPTURE_DR of the status/read register.

Parameters:
- TIMEOUT_CYCLES, 4095: tck cycles a transaction may stay outstanding before TIMEOUT status is reported; 0 disables the timeout.
- AXI_PROT, 3'b000: constant value driven on m_axi_awprot and m_axi_arprot.

Ports:
- tck  in  1  JTAG test clock; all flops on posedge.
- trstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  single-cycle start pulse (driven from UPDATE_DR decode).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  transaction address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- status_clr  in  1  returns status to STS_IDLE and clears overrun.
- busy  out  1  transaction in flight.
- status  out  3  axi_txn_status_t.
- rdata  out  32  last read data.
- overrun  out  1  sticky: a cmd_valid arrived while busy.
- m_axi_awvalid/awready/awaddr[31:0]/awprot[2:0]  AW channel (valid/addr/prot out, ready in).
- m_axi_wvalid/wready/wdata[31:0]/wstrb[3:0]  W channel.
- m_axi_bvalid/bready/bresp[1:0]  B channel.
- m_axi_arvalid/arready/araddr[31:0]/arprot[2:0]  AR channel.
- m_axi_rvalid/rready/rdata[31:0]/rresp[1:0]  R channel.

Behaviour:
- Clock and reset: single clock tck; asynchronous active-low reset trstn.
- Reset values: all valid and ready outputs 0, busy 0, status STS_IDLE, rdata 0, overrun 0, address/data outputs 0.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE + cmd_valid:
  - Latch addr, wdata and wstrb.
  - Next edge: busy=1, status=STS_BUSY, timeout counter=0.
  - Go to WR_REQ with awvalid=wvalid=1, or to RD_REQ with arvalid=1.
  - Valids are registered, so there is 1 cycle of latency from cmd_valid.
- WR_REQ:
  - awvalid and wvalid drop independently on their own handshake (tracked by aw_done and w_done flags).
  - When both are done, go to WR_RESP with bready=1.
  - AW and W may complete in the same or different cycles, in either order.
- WR_RESP:
  - On bvalid&&bready, map bresp: OKAY→STS_OKAY, EXOKAY→STS_OKAY, SLVERR→STS_SLVERR, DECERR→STS_DECERR.
  - Next edge: bready=0, busy=0, go to IDLE.
- RD_REQ: arvalid held until arready; then go to RD_RESP with rready=1.
- RD_RESP: on the rvalid handshake, rdata<=m_axi_rdata and status is mapped from rresp as above (rdata is captured even on error); then go to IDLE.
- AXI rules:
  - A valid is never deasserted before its handshake.
  - Addr, data and strb are stable while valid is high.
  - Only one outstanding transaction at a time.
- Timeout:
  - The counter increments every cycle while busy.
  - On reaching TIMEOUT_CYCLES, status=STS_TIMEOUT (sticky for this transaction).
  - Valids stay asserted until the handshake completes.
  - The late response is accepted and discarded: status stays TIMEOUT, rdata is unchanged.
  - busy clears only on completion.
  - The counter saturates; it does not wrap.
- cmd_valid while busy: ignored and sets overrun=1.
- status_clr:
  - In IDLE: status→STS_IDLE.
  - Always: overrun→0.
  - cmd_valid and status_clr in the same IDLE cycle: the command wins and status→STS_BUSY; overrun still clears.
- trstn low mid-transaction: all outputs return to reset values immediately, including dropping valids; a TAP reset is accepted as an interconnect-visible abort.

Decomposition:
- jtag_pkg adds:
  - axi_txn_status_t: STS_IDLE=0, STS_BUSY=1, STS_OKAY=2, STS_SLVERR=3, STS_DECERR=4, STS_TIMEOUT=5.
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR localparams.
  - jtag_axi_fsm_t with the state enum.
- One sub-module, jtag_axi_timeout: a saturating counter with clear/enable inputs and an expired output, width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Write, all ready high, cmd_addr=0x1000_0040, wdata=0xDEADBEEF, wstrb=0xF, bresp=OKAY:
  - awvalid/wvalid high 1 cycle after cmd_valid.
  - status=STS_OKAY and busy=0 two cycles after bvalid.
- Write skew, wready 5 cycles after awready, bresp=SLVERR: awvalid drops first, wvalid is held 5 cycles, status=STS_SLVERR.
- Read of 0x2000_0000, arready delayed 3 cycles, rdata=0xCAFE0001, rresp=DECERR: rdata=0xCAFE0001, status=STS_DECERR.
- TIMEOUT_CYCLES=16, arready withheld 40 cycles:
  - status=STS_TIMEOUT at cycle 16 while busy=1.
  - Late rvalid with rdata=0x1234 leaves rdata unchanged; busy→0.
- Second cmd_valid while busy: overrun=1, no second AW issued; status_clr in IDLE → status=STS_IDLE, overrun=0.
- trstn pulsed low with awvalid high: awvalid=0, busy=0, status=STS_IDLE asynchronously; the next command runs normally.
